nbit_sync_updown_mod: RTL

Synchronous n-bit up/down counter with a programmable modulus, parallel load, wrap or saturate behaviour, and terminal-count flags. It is the fully clocked counterpart of the team's ripple up/down counter. All bits change on the same `clk` edge, so `y` can be sampled by downstream synchronous logic without ripple glitches. It sits wherever a counter value feeds decode or compare logic: timers, address generators, prescalers.

---
 rtl/nbit_sync_updown_mod_pkg.sv | 11 +
 rtl/nbit_sync_updown_mod_tff_sync.sv | 17 +
 rtl/nbit_sync_updown_mod.sv | 90 +++++++++
 3 files changed

// File: rtl/nbit_sync_updown_mod_pkg.sv
// Shared counter constants.
// Direction and boundary-behaviour encodings.
package nbit_sync_updown_mod_pkg;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

  localparam logic SAT_WRAP  = 1'b0;
  localparam logic SAT_HOLD  = 1'b1;

endpackage

// File: rtl/nbit_sync_updown_mod_tff_sync.sv
// T flip-flop, synchronous toggle enable,
// asynchronous active-low reset.
module tff_sync (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q <= 1'b0;
    else if (t)
      q <= ~q;
  end

endmodule

// File: rtl/nbit_sync_updown_mod.sv
// Synchronous up/down counter with modulus, load,
// wrap/saturate and terminal-count flags.
module nbit_sync_updown_mod
  import nbit_sync_updown_mod_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         mode,
  input  logic         sat,
  input  logic         load,
  input  logic [n-1:0] din,
  input  logic [n-1:0] limit,
  output logic [n-1:0] y,
  output logic         tc,
  output logic         wrap
);

  localparam logic [n-1:0] ONE  = n'(1);
  localparam logic [n-1:0] ZERO = '0;

  logic [n-1:0] y_next;
  logic [n-1:0] tmask;
  logic         wrap_next;
  logic         at_lim;
  logic         at_zero;
  logic         up;
  logic         hold;

  assign at_lim  = (y >= limit);
  assign at_zero = (y == ZERO);
  assign up      = (mode == MODE_UP);
  assign hold    = (sat == SAT_HOLD);

  assign tc = (up & at_lim) | (~up & at_zero);

  // Out-of-range counts going up are treated as sitting on the limit.
  always_comb begin
    y_next    = y;
    wrap_next = 1'b0;
    unique case (1'b1)
      load: begin
        y_next = (din > limit) ? limit : din;
      end
      (!load && en && up): begin
        if (!at_lim)
          y_next = y + ONE;
        else if (hold)
          y_next = limit;
        else begin
          y_next    = ZERO;
          wrap_next = 1'b1;
        end
      end
      (!load && en && !up): begin
        if (!at_zero)
          y_next = y - ONE;
        else if (!hold) begin
          y_next    = limit;
          wrap_next = 1'b1;
        end
      end
      default: begin
        y_next    = y;
        wrap_next = 1'b0;
      end
    endcase
  end

  assign tmask = y ^ y_next;

  for (genvar i = 0; i < n; i++) begin : g_bit
    tff_sync u_tff (
      .clk (clk),
      .rst (rst),
      .t   (tmask[i]),
      .q   (y[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wrap <= 1'b0;
    else
      wrap <= wrap_next;
  end

endmodule
